// File: rtl/shift_sched_pkg.sv
// rtl/shift_sched_pkg.sv - shared types, constants and sign-magnitude field macros for shift_sched
`ifndef SM_FIELDS_SVH
`define SM_FIELDS_SVH
`define SM_SIGN(x, n) x[(n)-1]
`define SM_MAG(x, n) x[(n)-2:0]
`endif

package shift_sched_pkg;
   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with pointer register
module rr_arb2
   import shift_sched_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic               o_idx
);
   logic ptr_q, ptr_d;
   logic any_gnt;

   always_comb begin
      any_gnt = i_en & (|i_req);
      o_idx   = i_req[ptr_q] ? ptr_q : ~ptr_q;
      o_gnt   = '0;
      if (any_gnt) o_gnt[o_idx] = 1'b1;
      // Pointer favours the other requester next time.
      ptr_d   = any_gnt ? ~o_idx : ptr_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) ptr_q <= 1'b0;
      else       ptr_q <= ptr_d;
   end
endmodule

// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - shared sequential sign-magnitude left shifter for two requesters
module shift_sched
   import shift_sched_pkg::*;
#(
   parameter int N = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [N-1:0]       i_a0,
   input  logic [N-1:0]       i_b0,
   input  logic [N-1:0]       i_a1,
   input  logic [N-1:0]       i_b1,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic               o_busy,
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_id,
   output logic [N-1:0]       o_out,
   output logic               o_err,
   output logic               o_ovf
);
   localparam int CW = $clog2(N);
   localparam logic [N-2:0]  MAX_SHIFT = (N-1)'(N-1);
   localparam logic [CW-1:0] MAX_CNT   = CW'(N-1);

   state_e         state_q, state_d;
   logic           sign_q, sign_d;
   logic [N-2:0]   mag_q, mag_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           id_q, id_d;
   logic           err_q, err_d;
   logic           ovf_q, ovf_d;

   logic           arb_en;
   logic           arb_idx;
   logic [N-1:0]   a_sel, b_sel;
   logic [N-2:0]   b_mag;
   logic [CW-1:0]  cnt_eff;

   assign arb_en = (state_q == ST_IDLE) & ~i_rst;

   rr_arb2 u_arb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_req (i_req),
      .i_en  (arb_en),
      .o_gnt (o_gnt),
      .o_idx (arb_idx)
   );

   always_comb begin
      a_sel   = arb_idx ? i_a1 : i_a0;
      b_sel   = arb_idx ? i_b1 : i_b0;
      b_mag   = `SM_MAG(b_sel, N);
      // Shifts beyond N-1 cannot change the outcome, so saturate the count.
      cnt_eff = (b_mag >= MAX_SHIFT) ? MAX_CNT : b_mag[CW-1:0];

      state_d = state_q;
      sign_d  = sign_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      err_d   = err_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (|o_gnt) begin
               id_d = arb_idx;
               if (`SM_SIGN(b_sel, N)) begin
                  sign_d  = 1'b0;
                  mag_d   = '0;
                  err_d   = 1'b1;
                  ovf_d   = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  sign_d  = `SM_SIGN(a_sel, N);
                  mag_d   = `SM_MAG(a_sel, N);
                  err_d   = 1'b0;
                  ovf_d   = 1'b0;
                  cnt_d   = cnt_eff;
                  state_d = (cnt_eff == '0) ? ST_DONE : ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            ovf_d = ovf_q | mag_q[N-2];
            mag_d = {mag_q[N-3:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         sign_q  <= 1'b0;
         mag_q   <= '0;
         cnt_q   <= '0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_busy  = (state_q != ST_IDLE);
   assign o_valid = (state_q == ST_DONE);
   assign o_id    = id_q;
   assign o_out   = {sign_q, mag_q};
   assign o_err   = err_q;
   assign o_ovf   = ovf_q;
endmodule

// File: tb/tb_shift_sched.sv
// tb/tb_shift_sched.sv - directed self-checking bench for shift_sched
module tb_shift_sched;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         i_rst;
   logic [1:0]   i_req;
   logic [N-1:0] i_a0, i_b0, i_a1, i_b1;
   logic [1:0]   o_gnt;
   logic         o_busy, o_valid, i_ready, o_id, o_err, o_ovf;
   logic [N-1:0] o_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   shift_sched #(.N(N)) dut (
      .i_clk   (clk),
      .i_rst   (i_rst),
      .i_req   (i_req),
      .i_a0    (i_a0),
      .i_b0    (i_b0),
      .i_a1    (i_a1),
      .i_b1    (i_b1),
      .o_gnt   (o_gnt),
      .o_busy  (o_busy),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_id    (o_id),
      .o_out   (o_out),
      .o_err   (o_err),
      .o_ovf   (o_ovf)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives one request from an idle DUT; returns o_gnt seen in the grant cycle.
   task automatic issue(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [1:0] gnt_seen);
      if (k == 0) begin i_a0 = a; i_b0 = b; i_req = 2'b01; end
      else        begin i_a1 = a; i_b1 = b; i_req = 2'b10; end
      #1 gnt_seen = o_gnt;
      tick;
      i_req = 2'b00;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!o_valid && lat < 20) begin
         tick;
         lat++;
      end
   endtask

   task automatic accept;
      i_ready = 1'b1;
      tick;
      i_ready = 1'b0;
   endtask

   task automatic test_reset;
      i_rst = 1'b1; i_req = 2'b00; i_ready = 1'b0;
      i_a0 = '0; i_b0 = '0; i_a1 = '0; i_b1 = '0;
      tick;
      tick;
      checks++;
      if ({o_gnt, o_busy, o_valid, o_id, o_out, o_err, o_ovf} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: gnt=%b busy=%b valid=%b id=%b out=%h err=%b ovf=%b, required all zero",
                  o_gnt, o_busy, o_valid, o_id, o_out, o_err, o_ovf);
      end
      i_rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [1:0] g;
      int lat;
      issue(0, 8'h85, 8'h02, g);
      checks++; if (g !== 2'b01) begin errors++; $display("FAIL basic_gnt: got %b, required 01", g); end
      wait_valid(lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d, required 3", lat); end
      checks++;
      if (o_out !== 8'h94 || o_ovf !== 1'b0 || o_err !== 1'b0 || o_id !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: out=%h ovf=%b err=%b id=%b, required out=94 ovf=0 err=0 id=0", o_out, o_ovf, o_err, o_id);
      end
      accept;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b, required 0", o_valid); end
   endtask

   task automatic test_stall;
      logic [1:0] g;
      int lat;
      issue(1, 8'h21, 8'h02, g);
      checks++; if (g !== 2'b10) begin errors++; $display("FAIL stall_gnt: got %b, required 10", g); end
      wait_valid(lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL stall_latency: got %0d, required 3", lat); end
      i_a0 = 8'h05; i_b0 = 8'h00; i_req = 2'b01;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (o_gnt !== 2'b00 || o_valid !== 1'b1 || o_out !== 8'h04 || o_ovf !== 1'b1 || o_id !== 1'b1 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: gnt=%b valid=%b out=%h ovf=%b id=%b err=%b, required gnt=00 valid=1 out=04 ovf=1 id=1 err=0",
                     i, o_gnt, o_valid, o_out, o_ovf, o_id, o_err);
         end
         tick;
      end
      i_ready = 1'b1;
      #1;
      checks++; if (o_gnt !== 2'b00) begin errors++; $display("FAIL stall_accept_gnt: got %b, required 00", o_gnt); end
      tick;
      i_ready = 1'b0;
      #1;
      checks++; if (o_gnt !== 2'b01) begin errors++; $display("FAIL stall_next_gnt: got %b, required 01", o_gnt); end
      i_req = 2'b00;
      tick;
   endtask

   task automatic test_error_and_saturate;
      logic [1:0] g;
      int lat;
      issue(0, 8'h33, 8'h81, g);
      wait_valid(lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL err_latency: got %0d, required 1", lat); end
      checks++;
      if (o_err !== 1'b1 || o_out !== 8'h00 || o_ovf !== 1'b0) begin
         errors++;
         $display("FAIL err_result: err=%b out=%h ovf=%b, required err=1 out=00 ovf=0", o_err, o_out, o_ovf);
      end
      accept;
      issue(0, 8'h01, 8'h7F, g);
      wait_valid(lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL sat_latency: got %0d, required 8", lat); end
      checks++;
      if (o_out !== 8'h00 || o_ovf !== 1'b1 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL sat_result: out=%h ovf=%b err=%b, required out=00 ovf=1 err=0", o_out, o_ovf, o_err);
      end
      accept;
   endtask

   task automatic test_boundary;
      logic [1:0] g;
      int lat;
      issue(1, 8'h80, 8'h7F, g);
      wait_valid(lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL negzero_latency: got %0d, required 8", lat); end
      checks++;
      if (o_out !== 8'h80 || o_ovf !== 1'b0) begin
         errors++;
         $display("FAIL negzero_result: out=%h ovf=%b, required out=80 ovf=0", o_out, o_ovf);
      end
      accept;
      issue(0, 8'h05, 8'h00, g);
      wait_valid(lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL zero_shift_latency: got %0d, required 1", lat); end
      checks++;
      if (o_out !== 8'h05 || o_ovf !== 1'b0 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL zero_shift_result: out=%h ovf=%b err=%b, required out=05 ovf=0 err=0", o_out, o_ovf, o_err);
      end
      accept;
   endtask

   task automatic test_back_to_back;
      logic exp;
      i_rst = 1'b1;
      i_a0 = 8'h11; i_b0 = 8'h00; i_a1 = 8'h22; i_b1 = 8'h00;
      i_req = 2'b11; i_ready = 1'b1;
      #1;
      checks++; if (o_gnt !== 2'b00) begin errors++; $display("FAIL b2b_gnt_in_reset: got %b, required 00", o_gnt); end
      tick;
      i_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp = (i % 2) == 1;
         #1;
         checks++;
         if (o_gnt !== (exp ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL b2b_gnt[%0d]: got %b, required %b", i, o_gnt, exp ? 2'b10 : 2'b01);
         end
         tick;
         checks++;
         if (o_valid !== 1'b1 || o_id !== exp || o_out !== (exp ? 8'h22 : 8'h11) || o_gnt !== 2'b00) begin
            errors++;
            $display("FAIL b2b_result[%0d]: valid=%b id=%b out=%h gnt=%b, required valid=1 id=%b out=%h gnt=00",
                     i, o_valid, o_id, o_out, o_gnt, exp, exp ? 8'h22 : 8'h11);
         end
         tick;
      end
      i_req = 2'b00;
      i_ready = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid;
      logic [1:0] g;
      int lat;
      issue(0, 8'h01, 8'h05, g);
      tick;
      i_rst = 1'b1;
      i_a0 = 8'h44; i_b0 = 8'h00; i_a1 = 8'h66; i_b1 = 8'h00;
      i_req = 2'b11;
      #1;
      checks++; if (o_gnt !== 2'b00) begin errors++; $display("FAIL midrst_gnt_in_reset: got %b, required 00", o_gnt); end
      i_req = 2'b00;
      tick;
      checks++;
      if ({o_gnt, o_busy, o_valid, o_id, o_out, o_err, o_ovf} !== '0) begin
         errors++;
         $display("FAIL midrst_outputs: gnt=%b busy=%b valid=%b id=%b out=%h err=%b ovf=%b, required all zero",
                  o_gnt, o_busy, o_valid, o_id, o_out, o_err, o_ovf);
      end
      i_rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         checks++;
         if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet[%0d]: valid=%b busy=%b, required 0 0", i, o_valid, o_busy);
         end
      end
      i_req = 2'b11;
      #1;
      checks++; if (o_gnt !== 2'b01) begin errors++; $display("FAIL midrst_ptr: got %b, required 01", o_gnt); end
      tick;
      i_req = 2'b00;
      wait_valid(lat);
      checks++;
      if (lat !== 1 || o_out !== 8'h44 || o_id !== 1'b0) begin
         errors++;
         $display("FAIL midrst_after: lat=%0d out=%h id=%b, required lat=1 out=44 id=0", lat, o_out, o_id);
      end
      accept;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_error_and_saturate();
      test_boundary();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/shift_sched.md
Name: shift_sched

Overview:
- Shared, sequenced sign-magnitude left-shift unit for two requesters (e.g. two ALU issue slots).
- A round-robin arbiter accepts one request at a time. A multi-cycle iterator then shifts the magnitude one bit per cycle, with sticky overflow detection.
- Result is returned on a valid/ready handshake tagged with the requester ID.
- Arithmetic semantics match the team's combinational shifter: negative B is an error; any 1 shifted out of the magnitude field is overflow.

Parameters:
- N, 8, operand/result width; bit N-1 is sign, bits N-2:0 are magnitude.
- CW, $clog2(N), width of shift iteration counter (derived, not overridden).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_req  input  2  per-requester request; held until granted.
- i_a0  input  N  requester 0 operand A (sign-magnitude).
- i_b0  input  N  requester 0 shift amount B (sign-magnitude).
- i_a1  input  N  requester 1 operand A.
- i_b1  input  N  requester 1 shift amount B.
- o_gnt  output  2  one-hot, one-cycle pulse; operands sampled this cycle.
- o_busy  output  1  high whenever not IDLE.
- o_valid  output  1  result available.
- i_ready  input  1  consumer accepts result when o_valid & i_ready.
- o_id  output  1  requester that owns the current result.
- o_out  output  N  result {sign A, shifted magnitude}.
- o_err  output  1  B negative.
- o_ovf  output  1  nonzero bit shifted out of the magnitude.

Behaviour:
- Reset (synchronous, active-high, dominates everything, including mid-operation): state IDLE; o_gnt=0, o_busy=0, o_valid=0, o_id=0, o_out=0, o_err=0, o_ovf=0; RR pointer=0. Any in-flight operation is discarded, with no valid and no grant.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If any i_req bit is set, grant one requester: pointer requester if requesting, else the other.
  - o_gnt[k]=1 for that cycle; latch sign A, magnitude A and magnitude B from requester k; o_id<=k; pointer<=~k.
  - If sign B=1: o_err<=1, o_out<=0, o_ovf<=0, go to DONE.
  - Else cnt_eff=min(|B|, N-1). If cnt_eff=0, go to DONE with o_out=A and o_ovf=0. Otherwise load cnt with cnt_eff, clear sticky ovf, go to SHIFT.
- SHIFT, each cycle:
  - ovf |= mag[N-2]; mag <= mag<<1 (zero fill); cnt <= cnt-1.
  - On the cycle cnt==1, go to DONE.
  - |B| >= N-1 saturates at N-1 iterations: final magnitude 0, ovf = (original magnitude != 0).
- DONE:
  - o_valid=1; o_out={sign A, mag}; o_err/o_ovf stable.
  - Outputs are held until i_ready. On o_valid & i_ready, return to IDLE; o_valid falls the next cycle.
  - No new grant is issued in the same cycle as result acceptance; the earliest new grant is the cycle after.
- Latency, grant cycle to o_valid: 1 + cnt_eff cycles. Error path: 1 cycle.
- Both requesters held continuously: grants alternate 0,1,0,1, starting at 0 after reset.
- Negative-zero A (0x80 at N=8) keeps its sign bit: result 0x80, ovf=0.
- o_gnt is never asserted outside IDLE; requests arriving while busy wait.

Decomposition:
- Package shift_sched_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - localparam requester count, fixed at 2.
- Sign/magnitude field extraction uses the team's shared sign-magnitude macro header.
- Sub-module rr_arb2 contains:
  - the 2-way round-robin arbiter: inputs req[1:0] and enable; outputs one-hot gnt and grant index;
  - the pointer register, updated on grant.

Test Plan (N=8):
- Reset, then req0: A=0x85, B=0x02 -> gnt0 pulse; o_valid 3 cycles after grant; o_out=0x94, o_ovf=0, o_err=0, o_id=0.
- req1: A=0x21, B=0x02 -> o_out=0x04, o_ovf=1, o_id=1; with i_ready held low 5 cycles, outputs stable and no grant issued.
- req0: B=0x81 -> o_err=1, o_out=0x00, o_ovf=0, valid 1 cycle after grant. Second case A=0x01, B=0x7F -> 7 iterations, valid 8 cycles after grant, o_out=0x00, o_ovf=1.
- A=0x80, B=0x7F -> o_out=0x80, o_ovf=0. A=0x05, B=0x00 -> valid 1 cycle after grant, o_out=0x05.
- Both req held from reset with i_ready=1 -> grant order 0,1,0,1; o_id matches; each request granted exactly once per acceptance.
- i_rst asserted mid-SHIFT (A=0x01, B=0x05, 2 cycles in) -> next cycle all outputs 0, state IDLE, pointer 0; no valid appears for the aborted operation.
